// File: rtl/instruction_fetch_pkg.sv
// -----------------------------------------------------------------------------
// instruction_fetch_pkg
// Shared definitions for the instruction fetch unit: the fetch FSM state
// encoding, the default reset address and sequential PC increment, and a
// small alignment helper used by the next-PC logic.
// -----------------------------------------------------------------------------
package instruction_fetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int unsigned PC_STEP_DEFAULT  = 4;

    typedef enum logic [1:0] {
        FETCH_S_IDLE  = 2'd0,
        FETCH_S_REQ   = 2'd1,
        FETCH_S_HOLD  = 2'd2,
        FETCH_S_FAULT = 2'd3
    } fetch_state_t;

    // Instructions are word aligned; any set bit in [1:0] is a fetch fault.
    function automatic logic is_word_aligned(input logic [31:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/fetch_pc_gen.sv
// -----------------------------------------------------------------------------
// fetch_pc_gen
// Next-PC selection for the fetch unit. A redirect always wins, otherwise an
// accepted fetch advances the PC by PC_STEP (wrapping modulo 2^32), otherwise
// the PC holds. Also reports whether a redirect target is misaligned so the
// fetch FSM can enter its fault state.
//
// Ports:
//   pc                  current fetch PC
//   redirect            load redirect_pc this cycle
//   redirect_pc         redirect target
//   advance             current fetch was accepted, step to the next word
//   next_pc             PC value for the next cycle
//   redirect_misaligned redirect requested to a non word-aligned target
// -----------------------------------------------------------------------------
module fetch_pc_gen
    import instruction_fetch_pkg::*;
#(
    parameter int unsigned PC_STEP = PC_STEP_DEFAULT
) (
    input  logic [31:0] pc,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        advance,
    output logic [31:0] next_pc,
    output logic        redirect_misaligned
);

    // The misaligned target is still loaded so the trap handler can read it
    // back as the faulting address.
    always_comb begin
        next_pc = pc;
        if (redirect) begin
            next_pc = redirect_pc;
        end else if (advance) begin
            next_pc = pc + 32'(PC_STEP);
        end
    end

    assign redirect_misaligned = redirect && !is_word_aligned(redirect_pc);

endmodule

// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
// Requester side of the instruction memory interface. Owns the fetch PC,
// issues one request at a time, captures the acknowledged word and offers it
// to decode on a valid/ready handshake. Redirects from branch/jump/trap logic
// flush any held instruction; a misaligned redirect parks the unit in a fault
// state until an aligned redirect arrives.
//
// Ports:
//   i_clk                  clock, rising edge
//   i_rst                  synchronous active-high reset
//   o_pc                   fetch address to program memory
//   o_instruction_request  fetch request (level, high only while requesting)
//   i_instruction          instruction word from memory
//   i_awk                  memory acknowledge, i_instruction valid this cycle
//   i_redirect             load i_redirect_pc and flush
//   i_redirect_pc          redirect target
//   i_decode_ready         decode accepts o_inst this cycle
//   o_inst_valid           o_inst / o_inst_pc hold a fetched instruction
//   o_inst                 fetched instruction
//   o_inst_pc              address o_inst was fetched from
//   o_fetch_fault          misaligned redirect target seen
// -----------------------------------------------------------------------------
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned PC_STEP  = PC_STEP_DEFAULT
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic [31:0] o_pc,
    output logic        o_instruction_request,
    input  logic [31:0] i_instruction,
    input  logic        i_awk,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    input  logic        i_decode_ready,
    output logic        o_inst_valid,
    output logic [31:0] o_inst,
    output logic [31:0] o_inst_pc,
    output logic        o_fetch_fault
);

    fetch_state_t state;
    fetch_state_t next_state;

    logic [31:0] pc_q;
    logic [31:0] next_pc;
    logic        ack_accept;
    logic        handshake;
    logic        redirect_misaligned;

    // An acknowledge only counts while requesting, and a coincident redirect
    // drops the returned word.
    assign ack_accept = (state == FETCH_S_REQ) && i_awk && !i_redirect;
    assign handshake  = (state == FETCH_S_HOLD) && i_decode_ready;

    fetch_pc_gen #(
        .PC_STEP (PC_STEP)
    ) u_pc_gen (
        .pc                  (pc_q),
        .redirect            (i_redirect),
        .redirect_pc         (i_redirect_pc),
        .advance             (ack_accept),
        .next_pc             (next_pc),
        .redirect_misaligned (redirect_misaligned)
    );

    // Next-state logic; a redirect overrides whatever the FSM was doing.
    always_comb begin
        next_state = state;
        if (i_redirect) begin
            next_state = redirect_misaligned ? FETCH_S_FAULT : FETCH_S_REQ;
        end else begin
            case (state)
                FETCH_S_IDLE:  next_state = FETCH_S_REQ;
                FETCH_S_REQ:   if (i_awk) next_state = FETCH_S_HOLD;
                FETCH_S_HOLD:  if (i_decode_ready) next_state = FETCH_S_REQ;
                FETCH_S_FAULT: next_state = FETCH_S_FAULT;
                default:       next_state = FETCH_S_IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= FETCH_S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Registered outputs. The request is derived from next_state so it is high
    // exactly while the FSM sits in the request state. o_inst / o_inst_pc keep
    // their last value on a flush; only the valid flag is cleared.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pc_q                  <= RESET_PC;
            o_instruction_request <= 1'b0;
            o_inst_valid          <= 1'b0;
            o_inst                <= 32'h0;
            o_inst_pc             <= 32'h0;
            o_fetch_fault         <= 1'b0;
        end else begin
            pc_q                  <= next_pc;
            o_instruction_request <= (next_state == FETCH_S_REQ);
            if (i_redirect) begin
                o_inst_valid  <= 1'b0;
                o_fetch_fault <= redirect_misaligned;
            end else if (ack_accept) begin
                o_inst       <= i_instruction;
                o_inst_pc    <= pc_q;
                o_inst_valid <= 1'b1;
            end else if (handshake) begin
                o_inst_valid <= 1'b0;
            end
        end
    end

    assign o_pc = pc_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch
// Self-checking bench for instruction_fetch. A driver issues directed and
// random memory/decode/redirect stimulus and keeps a transaction-level model
// of the fetch stream (expected PC, fault flag, queue of instructions that
// should reach decode). A separate monitor compares whatever the DUT offers
// to decode against the head of that queue.
// -----------------------------------------------------------------------------
module tb_instruction_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] PC_STEP  = 32'd4;

    logic        i_clk;
    logic        i_rst;
    logic [31:0] o_pc;
    logic        o_instruction_request;
    logic [31:0] i_instruction;
    logic        i_awk;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;
    logic        i_decode_ready;
    logic        o_inst_valid;
    logic [31:0] o_inst;
    logic [31:0] o_inst_pc;
    logic        o_fetch_fault;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } fetch_t;

    fetch_t      sb_q[$];
    logic [31:0] exp_pc;
    logic        fault_mode;
    int          checks;
    int          errors;

    instruction_fetch dut (
        .i_clk                 (i_clk),
        .i_rst                 (i_rst),
        .o_pc                  (o_pc),
        .o_instruction_request (o_instruction_request),
        .i_instruction         (i_instruction),
        .i_awk                 (i_awk),
        .i_redirect            (i_redirect),
        .i_redirect_pc         (i_redirect_pc),
        .i_decode_ready        (i_decode_ready),
        .o_inst_valid          (o_inst_valid),
        .o_inst                (o_inst),
        .o_inst_pc             (o_inst_pc),
        .o_fetch_fault         (o_fetch_fault)
    );

    // Free-running clock.
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // Program memory contents as a pure function of the address; one fixed
    // word is planted at 0x14 for the decode back-pressure scenario.
    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        if (addr == 32'h0000_0014) return 32'h0050_0093;
        return (addr * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic compare(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Control outputs predicted from the model: a request is outstanding
    // whenever nothing is held for decode and the unit is not faulted.
    task automatic check_output();
        compare("pc", o_pc, exp_pc);
        compare("request", 32'(o_instruction_request), 32'(!fault_mode && sb_q.size() == 0));
        compare("inst_valid", 32'(o_inst_valid), 32'(sb_q.size() != 0));
        compare("fetch_fault", 32'(o_fetch_fault), 32'(fault_mode));
    endtask

    // One cycle of stimulus, after checking the state left by the last edge.
    task automatic apply_stimulus(input logic ack, input logic ready,
                                  input logic redir, input logic [31:0] target);
        logic exp_req;
        tick();
        check_output();
        exp_req        = !fault_mode && (sb_q.size() == 0);
        i_awk          = ack;
        i_decode_ready = ready;
        i_redirect     = redir;
        i_redirect_pc  = redir ? target : $urandom();
        i_instruction  = ack ? mem_word(o_pc) : $urandom();
        if (redir) begin
            sb_q.delete();
            exp_pc     = target;
            fault_mode = (target[1:0] != 2'b00);
        end else if (ack && exp_req) begin
            sb_q.push_back('{pc: exp_pc, word: mem_word(exp_pc)});
            exp_pc = exp_pc + PC_STEP;
        end
    endtask

    // Reset with noisy other inputs, then check every output's reset value.
    task automatic do_reset(input bit check_first);
        tick();
        if (check_first) check_output();
        i_rst          = 1'b1;
        i_awk          = 1'($urandom_range(0, 1));
        i_decode_ready = 1'($urandom_range(0, 1));
        i_redirect     = 1'($urandom_range(0, 1));
        i_redirect_pc  = $urandom();
        i_instruction  = $urandom();
        sb_q.delete();
        exp_pc     = RESET_PC;
        fault_mode = 1'b0;
        tick();
        compare("rst_pc", o_pc, RESET_PC);
        compare("rst_request", 32'(o_instruction_request), 32'h0);
        compare("rst_inst_valid", 32'(o_inst_valid), 32'h0);
        compare("rst_inst", o_inst, 32'h0);
        compare("rst_inst_pc", o_inst_pc, 32'h0);
        compare("rst_fetch_fault", 32'(o_fetch_fault), 32'h0);
        i_rst          = 1'b0;
        i_awk          = 1'b0;
        i_redirect     = 1'b0;
        i_decode_ready = 1'b0;
    endtask

    // Monitor: whatever the DUT offers decode must be the oldest expected
    // fetch; it is retired on a ready handshake that is not flushed.
    always @(negedge i_clk) begin
        if (!i_rst && !i_redirect && o_inst_valid) begin
            if (sb_q.size() == 0) begin
                compare("spurious_valid", 32'(o_inst_valid), 32'h0);
            end else begin
                compare("inst", o_inst, sb_q[0].word);
                compare("inst_pc", o_inst_pc, sb_q[0].pc);
                if (i_decode_ready) void'(sb_q.pop_front());
            end
        end
    end

    initial begin
        checks         = 0;
        errors         = 0;
        i_rst          = 1'b1;
        i_awk          = 1'b0;
        i_redirect     = 1'b0;
        i_redirect_pc  = 32'h0;
        i_decode_ready = 1'b0;
        i_instruction  = 32'h0;
        exp_pc         = RESET_PC;
        fault_mode     = 1'b0;

        do_reset(1'b0);

        // Back-to-back fetches from reset: 0, 4, 8.
        for (int k = 0; k < 6; k++) apply_stimulus(1'b1, 1'b1, 1'b0, 32'h0);

        // Slow memory at 0x10: three cycles without ack, then ack.
        apply_stimulus(1'b0, 1'b1, 1'b1, 32'h0000_0010);
        for (int k = 0; k < 3; k++) apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0);
        apply_stimulus(1'b1, 1'b1, 1'b0, 32'h0);
        apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0);

        // Fetch 0x14 and hold it against a stalled decode for five cycles.
        apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0);
        for (int k = 0; k < 5; k++) apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0);
        apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0);
        apply_stimulus(1'b1, 1'b1, 1'b0, 32'h0);
        apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0);

        // Redirect to 0x200 in the same cycle as an ack.
        apply_stimulus(1'b1, 1'b1, 1'b1, 32'h0000_0200);
        apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0);
        apply_stimulus(1'b1, 1'b1, 1'b0, 32'h0);
        apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0);

        // Misaligned redirect, ten idle fault cycles, then recovery at 0x300.
        apply_stimulus(1'b0, 1'b1, 1'b1, 32'h0000_0102);
        for (int k = 0; k < 10; k++) apply_stimulus(1'b1, 1'b1, 1'b0, 32'h0);
        apply_stimulus(1'b0, 1'b1, 1'b1, 32'h0000_0300);
        apply_stimulus(1'b1, 1'b1, 1'b0, 32'h0);
        apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0);

        // PC wrap at the top of the address space, then reset while holding.
        apply_stimulus(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC);
        apply_stimulus(1'b1, 1'b1, 1'b0, 32'h0);
        apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0);
        do_reset(1'b1);
        for (int k = 0; k < 4; k++) apply_stimulus(1'b1, 1'b1, 1'b0, 32'h0);

        // Random traffic: variable memory latency, decode stalls, redirects.
        for (int n = 0; n < 800; n++) begin
            logic        redir;
            logic [31:0] target;
            redir  = ($urandom_range(0, 24) == 0);
            target = $urandom() & 32'h0000_FFFC;
            if ($urandom_range(0, 7) == 0) target = 32'hFFFF_FFF0 | (target & 32'h0000_000C);
            if ($urandom_range(0, 4) == 0) target[1:0] = 2'($urandom_range(1, 3));
            apply_stimulus(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0), redir, target);
        end

        tick();
        check_output();
        i_awk          = 1'b0;
        i_redirect     = 1'b0;
        i_decode_ready = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
